jk_excitation_driver: RTL

Drives a bank of WIDTH externally instantiated JK flip-flops to a requested target word. It accepts targets over a valid/ready handshake and derives per-bit J/K excitations from the bank's observed outputs. After driving, it confirms that the bank reached the target and reports completion or error. It sits upstream of the team's JK flip-flop banks, which are sharing its clock, and acts as their write-side controller.

---
 rtl/jk_excitation_pkg.sv | 34 +++
 rtl/jk_excite.sv | 26 ++
 rtl/jk_excitation_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jk_excitation_pkg.sv
// ---------------------------------------------------------------------------
// jk_excitation_pkg
// Shared types and helpers for the JK excitation driver.
//   driverState_t : controller states (IDLE, DRIVE, CHECK)
//   EXC_*         : 2-bit excitation codes, packed as {J,K}
//   jkExcite()    : per-bit excitation for a (current Q, target Q) pair
// Optional feature macro used by the top level: JK_EXCITATION_DRIVER_RETRY_EN
// ---------------------------------------------------------------------------
package jk_excitation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } driverState_t;

    localparam logic [1:0] EXC_HOLD = 2'b00;
    localparam logic [1:0] EXC_SET  = 2'b10;
    localparam logic [1:0] EXC_RST  = 2'b01;

    // Don't-care cases of the JK excitation table are resolved to the
    // non-toggling choice, so J and K are never both high on one bit.
    function automatic logic [1:0] jkExcite(input logic q, input logic target);
        logic [1:0] code;
        code = EXC_HOLD;
        if (!q && target) begin
            code = EXC_SET;
        end else if (q && !target) begin
            code = EXC_RST;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// ---------------------------------------------------------------------------
// jk_excite
// Purely combinational WIDTH-wide JK excitation generator.
// Ports:
//   q      : in  WIDTH  current flop outputs
//   target : in  WIDTH  desired next flop state
//   j      : out WIDTH  J excitations
//   k      : out WIDTH  K excitations
// ---------------------------------------------------------------------------
module jk_excite
    import jk_excitation_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    // Each bit is independent; the package function holds the table.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {j[i], k[i]} = jkExcite(q[i], target[i]);
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
// Write-side controller for an external bank of WIDTH JK flip-flops sharing
// clk. Accepts a target word over valid/ready, drives J/K for one cycle,
// then checks the bank's feedback one cycle later and pulses done or err.
// Optional macro JK_EXCITATION_DRIVER_RETRY_EN: on a failed check, re-drive
// up to MAX_RETRY more times before reporting err.
// Ports:
//   clk        : in   clock, rising edge
//   reset_n    : in   asynchronous active-low reset
//   tgt_valid  : in   target offered
//   tgt_ready  : out  high exactly when IDLE
//   tgt_data   : in   WIDTH requested final bank state
//   q_fb       : in   WIDTH observed bank outputs
//   j, k       : out  WIDTH registered excitations
//   busy       : out  high whenever not IDLE
//   done, err  : out  one-cycle completion / failure pulses
// ---------------------------------------------------------------------------
module jk_excitation_driver
    import jk_excitation_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    driverState_t     r_state, w_nextState;
    logic [WIDTH-1:0] r_j, r_k, r_tgt;
    logic [WIDTH-1:0] w_nextJ, w_nextK, w_nextTgt;
    logic             r_done, r_err, w_nextDone, w_nextErr;
    logic [WIDTH-1:0] w_excTarget, w_excJ, w_excK;

`ifdef JK_EXCITATION_DRIVER_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] r_retry, w_nextRetry;
`else
    logic w_unused_maxRetry;
    assign w_unused_maxRetry = ^MAX_RETRY;
`endif

    // The handshake computes excitations against the incoming word; a
    // re-drive from CHECK computes them against the captured target.
    assign w_excTarget = (r_state == CHECK) ? r_tgt : tgt_data;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q      (q_fb),
        .target (w_excTarget),
        .j      (w_excJ),
        .k      (w_excK)
    );

    // Next-state and next-register logic. J/K default to zero so they are
    // only non-zero for the single DRIVE cycle following a load.
    always_comb begin
        w_nextState = r_state;
        w_nextJ     = '0;
        w_nextK     = '0;
        w_nextTgt   = r_tgt;
        w_nextDone  = 1'b0;
        w_nextErr   = 1'b0;
`ifdef JK_EXCITATION_DRIVER_RETRY_EN
        w_nextRetry = r_retry;
`endif
        unique case (r_state)
            IDLE: begin
                if (tgt_valid) begin
                    w_nextTgt   = tgt_data;
                    w_nextJ     = w_excJ;
                    w_nextK     = w_excK;
                    w_nextState = DRIVE;
`ifdef JK_EXCITATION_DRIVER_RETRY_EN
                    w_nextRetry = '0;
`endif
                end
            end
            DRIVE: begin
                w_nextState = CHECK;
            end
            CHECK: begin
                if (q_fb == r_tgt) begin
                    w_nextDone  = 1'b1;
                    w_nextState = IDLE;
                end else begin
`ifdef JK_EXCITATION_DRIVER_RETRY_EN
                    if (r_retry < RETRY_LIMIT) begin
                        w_nextRetry = r_retry + RETRY_W'(1);
                        w_nextJ     = w_excJ;
                        w_nextK     = w_excK;
                        w_nextState = DRIVE;
                    end else begin
                        w_nextErr   = 1'b1;
                        w_nextState = IDLE;
                    end
`else
                    w_nextErr   = 1'b1;
                    w_nextState = IDLE;
`endif
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_tgt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef JK_EXCITATION_DRIVER_RETRY_EN
            r_retry <= '0;
`endif
        end else begin
            r_state <= w_nextState;
            r_j     <= w_nextJ;
            r_k     <= w_nextK;
            r_tgt   <= w_nextTgt;
            r_done  <= w_nextDone;
            r_err   <= w_nextErr;
`ifdef JK_EXCITATION_DRIVER_RETRY_EN
            r_retry <= w_nextRetry;
`endif
        end
    end

    assign tgt_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign err       = r_err;

endmodule
